// File: rtl/ar_arbiter_if.sv
// AR channel bundle between two AXI masters, the arbiter and three slaves.
// The master modport is the environment side (masters + slaves driving in);
// the slave modport is the arbiter side.
interface ar_arbiter_if;
  logic [44:0] arpayload_m0;
  logic        arvalid_m0;
  logic        arready_m0;
  logic [44:0] arpayload_m1;
  logic        arvalid_m1;
  logic        arready_m1;
  logic [48:0] arpayload_s;
  logic [2:0]  arvalid_s;
  logic [2:0]  arready_s;
  logic [1:0]  rdone_m;

  modport master (
    output arpayload_m0, arvalid_m0, arpayload_m1, arvalid_m1, arready_s, rdone_m,
    input  arready_m0, arready_m1, arpayload_s, arvalid_s
  );

  modport slave (
    input  arpayload_m0, arvalid_m0, arpayload_m1, arvalid_m1, arready_s, rdone_m,
    output arready_m0, arready_m1, arpayload_s, arvalid_s
  );
endinterface

// File: rtl/ar_arbiter.sv
// AR channel arbiter: two masters onto three slaves, address decode to
// S0/S1/S2, ID tagging for R routing, per-master outstanding read cap.
// Optional macro AR_RR_EN: round-robin between masters (default: M0 fixed
// priority). Optional macro AXI_ASSERT: flag rdone on an idle counter.
module ar_arbiter #(
  parameter int unsigned MAX_OUTST = 1,
  parameter logic [31:0] S0_BASE   = 32'h0000_0000,
  parameter logic [31:0] S1_BASE   = 32'h0001_0000
) (
  input logic       clk,
  input logic       rst,
  ar_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT_M0, GNT_M1} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;          // one-hot slave select
  logic [2:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        elig0, elig1, pick1;
  logic [31:0] addr_win;
  logic [2:0]  dec_sel;
  logic        hs0, hs1;
  logic [48:0] pl_s;
  logic [2:0]  vld_s;
  logic        rdy0, rdy1;

  assign elig0 = bus.arvalid_m0 && (cnt0_q < MAX_CNT);
  assign elig1 = bus.arvalid_m1 && (cnt1_q < MAX_CNT);

`ifdef AR_RR_EN
  logic rr_q, rr_d;                   // 1: M1 favoured on a tie
  assign pick1 = elig1 && (!elig0 || rr_q);
`else
  assign pick1 = elig1 && !elig0;
`endif

  // Decode the address of whichever master would win this cycle
  assign addr_win = pick1 ? bus.arpayload_m1[40:9] : bus.arpayload_m0[40:9];
  always_comb begin
    dec_sel = 3'b100;
    if (addr_win[31:16] == S0_BASE[31:16])      dec_sel = 3'b001;
    else if (addr_win[31:16] == S1_BASE[31:16]) dec_sel = 3'b010;
  end

  assign hs0 = (state_q == GNT_M0) && |(bus.arready_s & sel_q);
  assign hs1 = (state_q == GNT_M1) && |(bus.arready_s & sel_q);

  // Issue and completion in the same cycle cancel; completion at zero is dropped
  function automatic logic [2:0] next_cnt(input logic [2:0] c, input logic inc,
                                          input logic dec);
    if (inc && !dec)                  return c + 3'd1;
    else if (!inc && dec && c != '0)  return c - 3'd1;
    else                              return c;
  endfunction

  // Outstanding counter next state
  always_comb begin
    cnt0_d = next_cnt(cnt0_q, hs0, bus.rdone_m[0]);
    cnt1_d = next_cnt(cnt1_q, hs1, bus.rdone_m[1]);
  end

  // Grant FSM next state and outputs; grant holds until the slave accepts
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pl_s    = '0;
    vld_s   = '0;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          state_d = pick1 ? GNT_M1 : GNT_M0;
          sel_d   = dec_sel;
        end
      end
      GNT_M0: begin
        pl_s  = {4'h1, bus.arpayload_m0};
        vld_s = sel_q;
        rdy0  = |(bus.arready_s & sel_q);
        if (hs0) state_d = IDLE;
      end
      GNT_M1: begin
        pl_s  = {4'h2, bus.arpayload_m1};
        vld_s = sel_q;
        rdy1  = |(bus.arready_s & sel_q);
        if (hs1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.arpayload_s = pl_s;
  assign bus.arvalid_s   = vld_s;
  assign bus.arready_m0  = rdy0;
  assign bus.arready_m1  = rdy1;

  // State, select and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

`ifdef AR_RR_EN
  // Pointer flips to the other master after each accepted AR
  always_comb begin
    rr_d = rr_q;
    if (hs0)      rr_d = 1'b1;
    else if (hs1) rr_d = 1'b0;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= 1'b0;
    else      rr_q <= rr_d;
  end
`endif

`ifdef AXI_ASSERT
  // A read completion with nothing outstanding is an R-channel protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(bus.rdone_m[0] && cnt0_q == '0 && !hs0))
        else $error("ar_arbiter: rdone_m[0] with no outstanding read");
      assert (!(bus.rdone_m[1] && cnt1_q == '0 && !hs1))
        else $error("ar_arbiter: rdone_m[1] with no outstanding read");
    end
  end
`endif
endmodule

// File: tb/tb_ar_arbiter.sv
// Directed bench for ar_arbiter (MAX_OUTST=1): vector table for single
// grants, outstanding cap, slave stall, default decode and counter corner
// cases, then hand sequences for arbitration order and reset mid-grant.
module tb_ar_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ar_arbiter_if bus ();
  ar_arbiter #(.MAX_OUTST(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [44:0] P0A = {4'h3, 32'h0000_0100, 4'h0, 3'd2, 2'd1};
  localparam logic [44:0] P0B = {4'h3, 32'h0001_0000, 4'h3, 3'd2, 2'd1};
  localparam logic [44:0] P1  = {4'h5, 32'h0001_0000, 4'h7, 3'd3, 2'd1};
  localparam logic [44:0] P2  = {4'h7, 32'h1000_0000, 4'h1, 3'd2, 2'd0};

  typedef struct {
    logic [44:0] p0; logic v0; logic [44:0] p1; logic v1;
    logic [2:0] rs; logic [1:0] rd;
    int g; logic [2:0] eavs; logic er0; logic er1;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int fails  = 0;

  function automatic void add(input logic [44:0] p0, input logic v0,
                              input logic [44:0] p1, input logic v1,
                              input logic [2:0] rs, input logic [1:0] rd,
                              input int g, input logic [2:0] eavs,
                              input logic er0, input logic er1);
    vec_t v;
    v.p0 = p0; v.v0 = v0; v.p1 = p1; v.v1 = v1; v.rs = rs; v.rd = rd;
    v.g = g; v.eavs = eavs; v.er0 = er0; v.er1 = er1;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [53:0] act, input logic [53:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got avs/r0/r1/pl=%h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [53:0] outs();
    return {bus.arvalid_s, bus.arready_m0, bus.arready_m1, bus.arpayload_s};
  endfunction

  // One cycle: drive at negedge, compare outputs just after
  task automatic cyc(input string nm, input logic [44:0] p0, input logic v0,
                     input logic [44:0] p1, input logic v1, input logic [2:0] rs,
                     input logic [1:0] rd, input int g, input logic [2:0] eavs,
                     input logic er0, input logic er1);
    logic [48:0] epl;
    @(negedge clk);
    bus.arpayload_m0 = p0; bus.arvalid_m0 = v0;
    bus.arpayload_m1 = p1; bus.arvalid_m1 = v1;
    bus.arready_s = rs;    bus.rdone_m = rd;
    #1;
    epl = (g == 1) ? {4'h1, p0} : (g == 2) ? {4'h2, p1} : 49'd0;
    chk(nm, outs(), {eavs, er0, er1, epl});
  endtask

  initial begin
    rst = 1'b0;
    bus.arpayload_m0 = '0; bus.arvalid_m0 = 1'b0;
    bus.arpayload_m1 = '0; bus.arvalid_m1 = 1'b0;
    bus.arready_s = '0;    bus.rdone_m = '0;

    // single read to S0
    add(P0A,1, P1,0, 3'b001,2'b00, 0,3'b000,0,0);
    add(P0A,1, P1,0, 3'b001,2'b00, 1,3'b001,1,0);
    add(P0A,0, P1,0, 3'b001,2'b00, 0,3'b000,0,0);
    // M0 capped, M1 granted, rdone frees M0 two cycles later
    add(P0A,1, P1,1, 3'b011,2'b00, 0,3'b000,0,0);
    add(P0A,1, P1,1, 3'b011,2'b00, 2,3'b010,0,1);
    add(P0A,1, P1,1, 3'b011,2'b00, 0,3'b000,0,0);
    add(P0A,1, P1,1, 3'b011,2'b01, 0,3'b000,0,0);
    add(P0A,1, P1,1, 3'b011,2'b00, 0,3'b000,0,0);
    add(P0A,1, P1,1, 3'b011,2'b00, 1,3'b001,1,0);
    add(P0A,0, P1,0, 3'b011,2'b11, 0,3'b000,0,0);
    // S1 stall for 5 cycles, M1 drops valid mid-stall (no de-grant)
    add(P0A,0, P1,1, 3'b000,2'b00, 0,3'b000,0,0);
    add(P0A,0, P1,1, 3'b000,2'b00, 2,3'b010,0,0);
    add(P0A,0, P1,1, 3'b000,2'b00, 2,3'b010,0,0);
    add(P0A,0, P1,0, 3'b000,2'b00, 2,3'b010,0,0);
    add(P0A,0, P1,0, 3'b000,2'b00, 2,3'b010,0,0);
    add(P0A,0, P1,1, 3'b000,2'b00, 2,3'b010,0,0);
    add(P0A,0, P1,1, 3'b010,2'b00, 2,3'b010,0,1);
    add(P0A,0, P1,0, 3'b000,2'b10, 0,3'b000,0,0);
    // default decode to S2; handshake + rdone leaves cnt1 at 0
    add(P0A,0, P2,1, 3'b100,2'b00, 0,3'b000,0,0);
    add(P0A,0, P2,1, 3'b100,2'b10, 2,3'b100,0,1);
    add(P0A,0, P2,1, 3'b100,2'b00, 0,3'b000,0,0);
    add(P0A,0, P2,1, 3'b100,2'b00, 2,3'b100,0,1);
    add(P0A,0, P2,1, 3'b100,2'b00, 0,3'b000,0,0);
    add(P0A,0, P2,0, 3'b100,2'b10, 0,3'b000,0,0);
    // rdone on idle counters must not underflow
    add(P0A,0, P1,0, 3'b011,2'b11, 0,3'b000,0,0);
    add(P0A,1, P1,1, 3'b011,2'b00, 0,3'b000,0,0);
    add(P0A,1, P1,1, 3'b011,2'b00, 1,3'b001,1,0);
    add(P0A,1, P1,1, 3'b011,2'b00, 0,3'b000,0,0);
    add(P0A,1, P1,1, 3'b011,2'b00, 2,3'b010,0,1);
    add(P0A,0, P1,0, 3'b011,2'b11, 0,3'b000,0,0);

    repeat (2) @(negedge clk);
    chk("reset", outs(), 54'd0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("vec%0d", i), tbl[i].p0, tbl[i].v0, tbl[i].p1, tbl[i].v1,
          tbl[i].rs, tbl[i].rd, tbl[i].g, tbl[i].eavs, tbl[i].er0, tbl[i].er1);

    // both masters always requesting S1, completion after each grant
    for (int k = 0; k < 4; k++) begin
      int w;
`ifdef AR_RR_EN
      w = (k % 2 == 1) ? 2 : 1;
`else
      w = 1;
`endif
      cyc($sformatf("arb_idle%0d", k), P0B,1, P1,1, 3'b010,2'b00, 0,3'b000,0,0);
      cyc($sformatf("arb_gnt%0d", k),  P0B,1, P1,1, 3'b010,2'b00, w,3'b010,
          (w == 1), (w == 2));
      cyc($sformatf("arb_done%0d", k), P0B,0, P1,0, 3'b010,
          (w == 1) ? 2'b01 : 2'b10, 0,3'b000,0,0);
    end

    // leave cnt1=1, then reset while M0 is granted and stalled
    cyc("rm_idle",  P0A,0, P1,1, 3'b010,2'b00, 0,3'b000,0,0);
    cyc("rm_m1",    P0A,0, P1,1, 3'b010,2'b00, 2,3'b010,0,1);
    cyc("rm_idle2", P0A,1, P1,0, 3'b000,2'b00, 0,3'b000,0,0);
    cyc("rm_m0",    P0A,1, P1,0, 3'b000,2'b00, 1,3'b001,0,0);
    rst = 1'b0;
    #1;
    chk("rst_mid", outs(), 54'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    cyc("post_idle",  P0A,1, P1,1, 3'b011,2'b00, 0,3'b000,0,0);
    cyc("post_m0",    P0A,1, P1,1, 3'b011,2'b00, 1,3'b001,1,0);
    cyc("post_idle2", P0A,0, P1,1, 3'b011,2'b00, 0,3'b000,0,0);
    cyc("post_m1",    P0A,0, P1,1, 3'b011,2'b00, 2,3'b010,0,1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
